jcount_monitor: RTL and testbench

- Downstream checker for the Johnson counter: samples the counter's parallel state every enabled clock.
- Decodes the state to a phase index and confirms each sample is the legal successor of the previous one.
- Flags illegal codes and sequence breaks, and counts completed revolutions.
- Sits between the Johnson counter and the status/display logic. Its outputs are the only health indication for the counter.

---
 rtl/jcount_monitor.sv | 170 +++++++++++++++++
 tb/tb_jcount_monitor.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/jcount_monitor.sv
// jcount_monitor: checks a Johnson counter's parallel state for legal codes
// and correct successor order, tracks lock, flags errors, counts revolutions.
// Ports:
//   in_clk, in_clr (async active-high), in_en (sample enable),
//   in_q (counter state), in_err_ack (clears sticky error).
//   o_phase, o_valid, o_locked, o_err, o_err_sticky, o_rev_cnt (registered).
module jcount_monitor #(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 2,
  parameter int REV_W    = 8,
  localparam int PW_RAW  = $clog2(2*WIDTH),
  localparam int PW      = (PW_RAW < 1) ? 1 : PW_RAW
) (
  input  logic             in_clk,
  input  logic             in_clr,
  input  logic             in_en,
  input  logic [WIDTH-1:0] in_q,
  input  logic             in_err_ack,
  output logic [PW-1:0]    o_phase,
  output logic             o_valid,
  output logic             o_locked,
  output logic             o_err,
  output logic             o_err_sticky,
  output logic [REV_W-1:0] o_rev_cnt
);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKING  = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  localparam logic [PW-1:0] LAST = PW'(2*WIDTH-1);
  localparam logic [3:0]    LCNT = 4'(LOCK_CNT);

  state_t           state_q, state_d;
  logic [3:0]       match_q, match_d;
  logic [PW-1:0]    phase_q, phase_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             sticky_q, sticky_d;
  logic [REV_W-1:0] rev_q, rev_d;

  logic             dec_legal;
  logic [PW-1:0]    dec_phase;
  logic [PW-1:0]    succ;
  logic             is_succ;
  logic             is_wrap;
  logic [3:0]       match_inc;

  function automatic logic [WIDTH-1:0] lsb_ones(input int n);
    logic [WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < WIDTH; i++) begin
      m[i] = (i < n);
    end
    return m;
  endfunction

  // Legal codes are a run of ones anchored at the LSB (phase = count)
  // or a run of ones anchored at the MSB over j zeros (phase = WIDTH+j).
  always_comb begin
    dec_legal = 1'b0;
    dec_phase = '0;
    for (int k = 0; k <= WIDTH; k++) begin
      if (in_q == lsb_ones(k)) begin
        dec_legal = 1'b1;
        dec_phase = PW'(k);
      end
    end
    for (int j = 1; j < WIDTH; j++) begin
      if (in_q == ~lsb_ones(j)) begin
        dec_legal = 1'b1;
        dec_phase = PW'(WIDTH + j);
      end
    end
  end

  assign succ      = (phase_q == LAST) ? '0 : phase_q + 1'b1;
  assign is_succ   = dec_legal && (dec_phase == succ);
  assign is_wrap   = is_succ && (phase_q == LAST);
  assign match_inc = match_q + 4'd1;

  always_comb begin
    state_d  = state_q;
    match_d  = match_q;
    phase_d  = phase_q;
    valid_d  = valid_q;
    err_d    = 1'b0;
    rev_d    = rev_q;
    sticky_d = in_err_ack ? 1'b0 : sticky_q;
    if (in_en) begin
      valid_d = dec_legal;
      if (dec_legal) begin
        phase_d = dec_phase;
      end
      unique case (state_q)
        UNLOCKED: begin
          if (dec_legal) begin
            match_d = '0;
            state_d = LOCKING;
          end
        end
        LOCKING: begin
          if (!dec_legal) begin
            state_d = UNLOCKED;
          end else if (is_succ) begin
            match_d = match_inc;
            if (match_inc == LCNT) begin
              state_d = LOCKED;
              // The locking sample itself may close a revolution.
              if (is_wrap) begin
                rev_d = rev_q + 1'b1;
              end
            end
          end else begin
            match_d = '0;
          end
        end
        LOCKED: begin
          if (!dec_legal) begin
            err_d   = 1'b1;
            state_d = UNLOCKED;
          end else if (!is_succ) begin
            err_d   = 1'b1;
            match_d = '0;
            state_d = LOCKING;
          end else if (is_wrap) begin
            rev_d = rev_q + 1'b1;
          end
        end
        default: begin
          state_d = UNLOCKED;
        end
      endcase
      // A new error outranks a same-cycle acknowledge.
      if (err_d) begin
        sticky_d = 1'b1;
      end
    end
  end

  always_ff @(posedge in_clk or posedge in_clr) begin
    if (in_clr) begin
      state_q  <= UNLOCKED;
      match_q  <= '0;
      phase_q  <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
      rev_q    <= '0;
    end else begin
      state_q  <= state_d;
      match_q  <= match_d;
      phase_q  <= phase_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      sticky_q <= sticky_d;
      rev_q    <= rev_d;
    end
  end

  assign o_phase      = phase_q;
  assign o_valid      = valid_q;
  assign o_locked     = (state_q == LOCKED);
  assign o_err        = err_q;
  assign o_err_sticky = sticky_q;
  assign o_rev_cnt    = rev_q;

endmodule

// File: tb/tb_jcount_monitor.sv
// tb_jcount_monitor: table vectors, hand sequences and randomized traffic
// checked against a ring-lookup reference model of jcount_monitor.
module tb_jcount_monitor;

  localparam int W  = 4;
  localparam int R  = 2 * W;
  localparam int LC = 2;

  logic       in_clk = 1'b0;
  logic       in_clr = 1'b1;
  logic       in_en = 1'b0;
  logic [3:0] in_q = '0;
  logic       in_err_ack = 1'b0;
  logic [2:0] o_phase;
  logic       o_valid;
  logic       o_locked;
  logic       o_err;
  logic       o_err_sticky;
  logic [7:0] o_rev_cnt;

  jcount_monitor #(.WIDTH(W), .LOCK_CNT(LC), .REV_W(8)) dut (
    .in_clk(in_clk),
    .in_clr(in_clr),
    .in_en(in_en),
    .in_q(in_q),
    .in_err_ack(in_err_ack),
    .o_phase(o_phase),
    .o_valid(o_valid),
    .o_locked(o_locked),
    .o_err(o_err),
    .o_err_sticky(o_err_sticky),
    .o_rev_cnt(o_rev_cnt)
  );

  always #5 in_clk = ~in_clk;

  int n_cmp = 0;
  int n_fail = 0;

  logic [3:0] ring [R];

  int m_state, m_match, m_phase, m_rev;
  bit m_valid, m_err, m_sticky;

  typedef struct {
    bit en; logic [3:0] q; bit ack;
    bit lk; int ph; bit v; bit e; bit s; int rv;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp,
               $time);
    end
  endtask

  function automatic int dec(input logic [3:0] q);
    for (int i = 0; i < R; i++) if (ring[i] == q) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_state = 0; m_match = 0; m_phase = 0; m_rev = 0;
    m_valid = 0; m_err = 0; m_sticky = 0;
  endtask

  task automatic model_step(input bit en, input logic [3:0] q,
                            input bit ack);
    int ph;
    bit ok, nxt, e;
    if (!en) begin
      m_err = 0;
      if (ack) m_sticky = 0;
      return;
    end
    ph = dec(q);
    ok = (ph >= 0);
    nxt = ok && (ph == (m_phase + 1) % R);
    e = 0;
    if (m_state == 0) begin
      if (ok) begin m_match = 0; m_state = 1; end
    end else if (m_state == 1) begin
      if (!ok) m_state = 0;
      else if (nxt) begin
        m_match++;
        if (m_match == LC) begin
          m_state = 2;
          if (m_phase == R - 1) m_rev = (m_rev + 1) % 256;
        end
      end else m_match = 0;
    end else begin
      if (!ok) begin e = 1; m_state = 0; end
      else if (!nxt) begin e = 1; m_state = 1; m_match = 0; end
      else if (m_phase == R - 1) m_rev = (m_rev + 1) % 256;
    end
    if (ok) m_phase = ph;
    m_valid = ok;
    m_err = e;
    if (e) m_sticky = 1;
    else if (ack) m_sticky = 0;
  endtask

  task automatic step(input bit en, input logic [3:0] q, input bit ack);
    in_en = en; in_q = q; in_err_ack = ack;
    @(posedge in_clk);
    model_step(en, q, ack);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".phase"},  32'(o_phase),      32'(m_phase));
    chk({tag, ".valid"},  32'(o_valid),      32'(m_valid));
    chk({tag, ".locked"}, 32'(o_locked),     32'(m_state == 2));
    chk({tag, ".err"},    32'(o_err),        32'(m_err));
    chk({tag, ".sticky"}, 32'(o_err_sticky), 32'(m_sticky));
    chk({tag, ".rev"},    32'(o_rev_cnt),    32'(m_rev));
  endtask

  // Pulse in_clr between edges and confirm outputs clear before any edge.
  task automatic async_reset(input string tag);
    #2 in_clr = 1'b1;
    #1;
    chk({tag, ".rst_phase"},  32'(o_phase),      0);
    chk({tag, ".rst_valid"},  32'(o_valid),      0);
    chk({tag, ".rst_locked"}, 32'(o_locked),     0);
    chk({tag, ".rst_err"},    32'(o_err),        0);
    chk({tag, ".rst_sticky"}, 32'(o_err_sticky), 0);
    chk({tag, ".rst_rev"},    32'(o_rev_cnt),    0);
    model_reset();
    #1 in_clr = 1'b0;
  endtask

  initial begin
    logic [3:0] r;
    int cur;
    r = '0;
    for (int i = 0; i < R; i++) begin
      ring[i] = r;
      r = {r[2:0], ~r[3]};
    end
    model_reset();

    tbl.push_back('{1, 4'b0000, 0, 0, 0, 1, 0, 0, 0});
    tbl.push_back('{1, 4'b0001, 0, 0, 1, 1, 0, 0, 0});
    tbl.push_back('{1, 4'b0011, 0, 1, 2, 1, 0, 0, 0});
    tbl.push_back('{1, 4'b0111, 0, 1, 3, 1, 0, 0, 0});
    tbl.push_back('{1, 4'b1100, 0, 0, 6, 1, 1, 1, 0});
    tbl.push_back('{1, 4'b1000, 0, 0, 7, 1, 0, 1, 0});
    tbl.push_back('{1, 4'b0000, 0, 1, 0, 1, 0, 1, 1});
    tbl.push_back('{1, 4'b0001, 0, 1, 1, 1, 0, 1, 1});
    tbl.push_back('{1, 4'b0101, 0, 0, 1, 0, 1, 1, 1});
    tbl.push_back('{1, 4'b0000, 0, 0, 0, 1, 0, 1, 1});
    tbl.push_back('{0, 4'b1111, 0, 0, 0, 1, 0, 1, 1});
    tbl.push_back('{0, 4'b0110, 1, 0, 0, 1, 0, 0, 1});
    tbl.push_back('{1, 4'b0001, 0, 0, 1, 1, 0, 0, 1});
    tbl.push_back('{1, 4'b0001, 0, 0, 1, 1, 0, 0, 1});
    tbl.push_back('{1, 4'b0101, 0, 0, 1, 0, 0, 0, 1});
    tbl.push_back('{1, 4'b0101, 0, 0, 1, 0, 0, 0, 1});

    repeat (2) @(posedge in_clk);
    #6 in_clr = 1'b0;
    #1;
    check_model("init");

    foreach (tbl[i]) begin
      step(tbl[i].en, tbl[i].q, tbl[i].ack);
      chk($sformatf("tbl%0d.locked", i), 32'(o_locked), 32'(tbl[i].lk));
      chk($sformatf("tbl%0d.phase", i), 32'(o_phase), 32'(tbl[i].ph));
      chk($sformatf("tbl%0d.valid", i), 32'(o_valid), 32'(tbl[i].v));
      chk($sformatf("tbl%0d.err", i), 32'(o_err), 32'(tbl[i].e));
      chk($sformatf("tbl%0d.sticky", i), 32'(o_err_sticky),
          32'(tbl[i].s));
      chk($sformatf("tbl%0d.rev", i), 32'(o_rev_cnt), 32'(tbl[i].rv));
    end

    async_reset("ring");
    for (int i = 0; i < 3; i++) step(1, ring[i], 0);
    chk("ring.lock", 32'(o_locked), 1);
    for (int rv = 0; rv < 256; rv++) begin
      for (int i = 0; i < R; i++) begin
        step(1, ring[(3 + i) % R], 0);
        check_model("ring");
        chk("ring.noerr", 32'(o_err), 0);
      end
      if (rv == 0) chk("ring.rev1", 32'(o_rev_cnt), 1);
    end
    chk("ring.wrap", 32'(o_rev_cnt), 0);
    chk("ring.locked", 32'(o_locked), 1);

    for (int i = 0; i < 5; i++) begin
      step(0, 4'($urandom), 0);
      check_model("gate");
      chk("gate.phase", 32'(o_phase), 2);
    end

    step(1, ring[5], 1);
    check_model("ackerr");
    chk("ackerr.sticky", 32'(o_err_sticky), 1);
    chk("ackerr.err", 32'(o_err), 1);
    step(1, ring[6], 1);
    check_model("ack");
    chk("ack.sticky", 32'(o_err_sticky), 0);

    async_reset("cnt");
    r = '0;
    for (int i = 0; i < 7; i++) begin
      step(1, r, 0);
      r = {r[2:0], ~r[3]};
      check_model("cnt");
      chk("cnt.sticky", 32'(o_err_sticky), 0);
      if (i >= 2) chk("cnt.locked", 32'(o_locked), 1);
    end

    cur = 6;
    for (int n = 0; n < 3000; n++) begin
      int pick;
      bit en;
      logic [3:0] q;
      pick = $urandom_range(0, 99);
      en = ($urandom_range(0, 99) < 85);
      if (pick < 82) q = ring[(cur + 1) % R];
      else if (pick < 92) q = 4'($urandom);
      else q = ring[$urandom_range(0, R - 1)];
      step(en, q, $urandom_range(0, 99) < 5);
      if (en && dec(q) >= 0) cur = dec(q);
      check_model("rand");
      if ($urandom_range(0, 999) < 3) async_reset("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp,
             n_fail);
    $finish;
  end

endmodule
